// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single byte-addressed data memory.
// Port 0 has priority. Port 1 is promoted after MAX_WAIT stalled cycles. Bad requests are answered with an error and never reach memory.
module dmem_arbiter #(
    parameter int MEM_BYTES = 32,
    parameter int MAX_WAIT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic        p0_we,
    input  logic [2:0]  p0_unit,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_rsp_valid,
    output logic        p0_rsp_err,
    output logic [31:0] p0_rsp_rdata,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic        p1_we,
    input  logic [2:0]  p1_unit,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_rsp_valid,
    output logic        p1_rsp_err,
    output logic [31:0] p1_rsp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_unit,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [CNT_W-1:0] starve_cnt_reg;
    logic             starved;
    logic             grant_any;
    logic             grant_port;
    logic             sel_we;
    logic [2:0]       sel_unit;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic [32:0]      sel_size;
    logic [32:0]      last_byte;
    logic             unit_bad;
    logic             misaligned;
    logic             out_of_range;
    logic             sel_err;
    logic             legal;

    logic             rsp_valid_reg;
    logic             rsp_port_reg;
    logic             rsp_err_reg;
    logic             rsp_load_reg;

    logic [1:0]       ready_vec;
    logic [1:0]       rsp_valid_vec;
    logic [1:0]       rsp_err_vec;
    logic [31:0]      rsp_rdata_vec [2];

    assign starved = (starve_cnt_reg == CNT_W'(MAX_WAIT));

    always_comb begin
        grant_port = p1_valid && (!p0_valid || starved);
        grant_any  = !rst && (p0_valid || p1_valid);
        sel_we     = grant_port ? p1_we    : p0_we;
        sel_unit   = grant_port ? p1_unit  : p0_unit;
        sel_addr   = grant_port ? p1_addr  : p0_addr;
        sel_wdata  = grant_port ? p1_wdata : p0_wdata;
    end

    // Access size from the unit code; 3, 6 and 7 are not real units.
    always_comb begin
        sel_size = 33'd1;
        unit_bad = 1'b0;
        case (sel_unit)
            3'd0, 3'd4: sel_size = 33'd1;
            3'd1, 3'd5: sel_size = 33'd2;
            3'd2:       sel_size = 33'd4;
            default:    unit_bad = 1'b1;
        endcase
        // Computed in 33 bits so addresses near 2^32 cannot wrap back into range.
        last_byte    = {1'b0, sel_addr} + sel_size - 33'd1;
        out_of_range = (last_byte >= 33'(MEM_BYTES));
        misaligned   = ((sel_size == 33'd2) && sel_addr[0]) ||
                       ((sel_size == 33'd4) && (sel_addr[1:0] != 2'b00));
        sel_err      = unit_bad || misaligned || out_of_range || (sel_we && sel_unit[2]);
        legal        = grant_any && !sel_err;
    end

    assign mem_read  = legal && !sel_we;
    assign mem_write = legal && sel_we;
    assign mem_unit  = legal ? sel_unit  : 3'd0;
    assign mem_addr  = legal ? sel_addr  : 32'd0;
    assign mem_wdata = legal ? sel_wdata : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_port_reg   <= 1'b0;
            rsp_err_reg    <= 1'b0;
            rsp_load_reg   <= 1'b0;
        end else begin
            if (!p1_valid || ready_vec[1]) begin
                starve_cnt_reg <= '0;
            end else if (!starved) begin
                starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
            end
            rsp_valid_reg <= grant_any;
            rsp_port_reg  <= grant_port;
            rsp_err_reg   <= sel_err;
            rsp_load_reg  <= !sel_we;
        end
    end

    // Per-port grant and response demux. Responses are masked during reset so a pending response is never issued.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign ready_vec[gi]     = grant_any && (grant_port == 1'(gi));
            assign rsp_valid_vec[gi] = !rst && rsp_valid_reg && (rsp_port_reg == 1'(gi));
            assign rsp_err_vec[gi]   = rsp_valid_vec[gi] && rsp_err_reg;
            assign rsp_rdata_vec[gi] = (rsp_valid_vec[gi] && !rsp_err_reg && rsp_load_reg) ?
                                       mem_rdata : 32'd0;
        end
    endgenerate

    assign p0_ready     = ready_vec[0];
    assign p1_ready     = ready_vec[1];
    assign p0_rsp_valid = rsp_valid_vec[0];
    assign p1_rsp_valid = rsp_valid_vec[1];
    assign p0_rsp_err   = rsp_err_vec[0];
    assign p1_rsp_err   = rsp_err_vec[1];
    assign p0_rsp_rdata = rsp_rdata_vec[0];
    assign p1_rsp_rdata = rsp_rdata_vec[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, corner-case sequences and random traffic.
// A byte-array memory sits on the mem_* side. A reference model checks grants and responses every cycle.
module tb_dmem_arbiter;
    localparam int MEM_BYTES = 32;
    localparam int MAX_WAIT  = 4;

    logic        clk;
    logic        rst;
    logic        p0_valid, p0_ready, p0_we, p0_rsp_valid, p0_rsp_err;
    logic [2:0]  p0_unit;
    logic [31:0] p0_addr, p0_wdata, p0_rsp_rdata;
    logic        p1_valid, p1_ready, p1_we, p1_rsp_valid, p1_rsp_err;
    logic [2:0]  p1_unit;
    logic [31:0] p1_addr, p1_wdata, p1_rsp_rdata;
    logic        mem_read, mem_write;
    logic [2:0]  mem_unit;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_unit(p0_unit),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid),
        .p0_rsp_err(p0_rsp_err), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_unit(p1_unit),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_err(p1_rsp_err), .p1_rsp_rdata(p1_rsp_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_unit(mem_unit),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory attached to the arbiter: little-endian, 1-cycle read latency, extends loads by unit.
    logic [7:0] bmem [MEM_BYTES];

    function automatic logic [31:0] bmem_rd(input logic [2:0] unit, input logic [31:0] addr);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (longint'(addr) + i < MEM_BYTES) v[i*8 +: 8] = bmem[int'(addr) + i];
        end
        case (unit)
            3'd0: return {{24{v[7]}}, v[7:0]};
            3'd4: return {24'd0, v[7:0]};
            3'd1: return {{16{v[15]}}, v[15:0]};
            3'd5: return {16'd0, v[15:0]};
            default: return v;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_write && mem_addr < 32'(MEM_BYTES)) begin
            bmem[mem_addr[4:0]] <= mem_wdata[7:0];
            if (mem_unit[1:0] != 2'd0 && mem_addr < 32'(MEM_BYTES - 1))
                bmem[mem_addr[4:0] + 5'd1] <= mem_wdata[15:8];
            if (mem_unit[1:0] == 2'd2 && mem_addr < 32'(MEM_BYTES - 3)) begin
                bmem[mem_addr[4:0] + 5'd2] <= mem_wdata[23:16];
                bmem[mem_addr[4:0] + 5'd3] <= mem_wdata[31:24];
            end
        end
        // Garbage when not reading, so any leak of raw mem_rdata into a response shows up.
        mem_rdata <= mem_read ? bmem_rd(mem_unit, mem_addr) : $urandom();
    end

    // ---------------- reference model ----------------
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ref_mem [MEM_BYTES];
    int          wait1;
    bit          pend_v;
    int          pend_port;
    bit          pend_err;
    logic [31:0] pend_rdata;
    bit          acc0, acc1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int unit_size(input int unit);
        case (unit)
            0, 4: return 1;
            1, 5: return 2;
            2: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit exp_err(input bit we, input int unit, input longint addr);
        int size;
        size = unit_size(unit);
        if (size == 0) return 1'b1;
        if (we && unit >= 4) return 1'b1;
        if (addr % size != 0) return 1'b1;
        if (addr + size > MEM_BYTES) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input int unit, input longint addr);
        longint v;
        int size;
        size = unit_size(unit);
        v = 0;
        for (int i = 0; i < size; i++) v += longint'(ref_mem[int'(addr) + i]) << (8 * i);
        if (unit < 4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
            v -= longint'(1) << (8 * size);
        return 32'(v);
    endfunction

    task automatic ref_store(input int unit, input longint addr, input logic [31:0] wdata);
        for (int i = 0; i < unit_size(unit); i++) ref_mem[int'(addr) + i] = wdata[i*8 +: 8];
    endtask

    // Checks every output for the current cycle, then advances the model past the next edge.
    task automatic check_cycle();
        bit g0, g1, e, we;
        int unit;
        logic [31:0] addr, wdata, rd;
        g1 = !rst && p1_valid && (!p0_valid || wait1 >= MAX_WAIT);
        g0 = !rst && p0_valid && !g1;
        chk("p0_ready", 32'(p0_ready), 32'(g0));
        chk("p1_ready", 32'(p1_ready), 32'(g1));
        e = 1'b0;
        we = g1 ? p1_we : p0_we;
        unit = int'(g1 ? p1_unit : p0_unit);
        addr = g1 ? p1_addr : p0_addr;
        wdata = g1 ? p1_wdata : p0_wdata;
        if (g0 || g1) begin
            e = exp_err(we, unit, longint'(addr));
            chk("mem_read", 32'(mem_read), 32'(!e && !we));
            chk("mem_write", 32'(mem_write), 32'(!e && we));
            if (!e) begin
                chk("mem_unit", 32'(mem_unit), 32'(unit));
                chk("mem_addr", mem_addr, addr);
                if (we) chk("mem_wdata", mem_wdata, wdata);
            end
        end else begin
            chk("mem_read_idle", 32'(mem_read), 32'd0);
            chk("mem_write_idle", 32'(mem_write), 32'd0);
        end
        chk("p0_rsp_valid", 32'(p0_rsp_valid), 32'(!rst && pend_v && pend_port == 0));
        chk("p1_rsp_valid", 32'(p1_rsp_valid), 32'(!rst && pend_v && pend_port == 1));
        chk("p0_rsp_err", 32'(p0_rsp_err), 32'(!rst && pend_v && pend_port == 0 && pend_err));
        chk("p1_rsp_err", 32'(p1_rsp_err), 32'(!rst && pend_v && pend_port == 1 && pend_err));
        chk("p0_rsp_rdata", p0_rsp_rdata, (!rst && pend_v && pend_port == 0) ? pend_rdata : 32'd0);
        chk("p1_rsp_rdata", p1_rsp_rdata, (!rst && pend_v && pend_port == 1) ? pend_rdata : 32'd0);
        if (rst) begin
            pend_v = 1'b0;
            wait1 = 0;
        end else begin
            pend_v = g0 || g1;
            pend_port = g1 ? 1 : 0;
            pend_err = e;
            rd = 32'd0;
            if ((g0 || g1) && !e) begin
                if (we) ref_store(unit, longint'(addr), wdata);
                else rd = ref_load(unit, longint'(addr));
            end
            pend_rdata = rd;
            if (!p1_valid || g1) wait1 = 0;
            else if (wait1 < MAX_WAIT) wait1++;
        end
        acc0 = g0;
        acc1 = g1;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int port, input bit v, input bit we, input logic [2:0] unit,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_valid = v; p0_we = we; p0_unit = unit; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_valid = v; p1_we = we; p1_unit = unit; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    typedef struct {
        int          port;
        bit          we;
        logic [2:0]  unit;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input int port, input bit we, input logic [2:0] unit,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input bit err, input logic [31:0] rdata);
        vec_t v;
        v.port = port; v.we = we; v.unit = unit; v.addr = addr; v.wdata = wdata;
        v.exp_err = err; v.exp_rdata = rdata;
        return v;
    endfunction

    vec_t vecs[$];
    bit   act0, act1;
    int   p1_at;

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            bmem[i] = 8'd0;
            ref_mem[i] = 8'd0;
        end
        mem_rdata = 32'd0;
        wait1 = 0; pend_v = 1'b0; pend_port = 0; pend_err = 1'b0; pend_rdata = 32'd0;
        rst = 1'b1;
        set_port(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        set_port(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        advance();
        tick();
        chk("reset_mem_unit", 32'(mem_unit), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        advance();
        rst = 1'b0;

        // Directed table: port, we, unit, addr, wdata, expected err, expected rdata.
        vecs.push_back(mk(0, 1, 3'd2, 32'h04, 32'hDEADBEEF, 0, 32'h0));
        vecs.push_back(mk(0, 0, 3'd2, 32'h04, 32'h0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 3'd1, 32'h03, 32'h0, 1, 32'h0));
        vecs.push_back(mk(1, 0, 3'd2, 32'h1C, 32'h0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 3'd2, 32'h1E, 32'h0, 1, 32'h0));
        vecs.push_back(mk(1, 0, 3'd1, 32'h20, 32'h0, 1, 32'h0));
        vecs.push_back(mk(0, 0, 3'd0, 32'h1F, 32'h0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 3'd0, 32'h10, 32'h12345680, 0, 32'h0));
        vecs.push_back(mk(0, 0, 3'd0, 32'h10, 32'h0, 0, 32'hFFFFFF80));
        vecs.push_back(mk(1, 0, 3'd4, 32'h10, 32'h0, 0, 32'h00000080));
        vecs.push_back(mk(0, 1, 3'd4, 32'h10, 32'h55, 1, 32'h0));
        vecs.push_back(mk(0, 0, 3'd3, 32'h00, 32'h0, 1, 32'h0));
        vecs.push_back(mk(1, 1, 3'd1, 32'h1E, 32'hCAFEBEEF, 0, 32'h0));
        vecs.push_back(mk(1, 0, 3'd5, 32'h1E, 32'h0, 0, 32'h0000BEEF));
        vecs.push_back(mk(0, 0, 3'd1, 32'h1E, 32'h0, 0, 32'hFFFFBEEF));
        vecs.push_back(mk(0, 0, 3'd2, 32'h1C, 32'h0, 0, 32'hBEEF0000));
        vecs.push_back(mk(1, 0, 3'd2, 32'hFFFFFFFC, 32'h0, 1, 32'h0));

        foreach (vecs[i]) begin
            set_port(vecs[i].port, 1'b1, vecs[i].we, vecs[i].unit, vecs[i].addr, vecs[i].wdata);
            tick();
            chk($sformatf("vec%0d_ready", i),
                32'(vecs[i].port == 0 ? p0_ready : p1_ready), 32'd1);
            chk($sformatf("vec%0d_mem_access", i), 32'(mem_read || mem_write), 32'(!vecs[i].exp_err));
            advance();
            set_port(vecs[i].port, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            tick();
            chk($sformatf("vec%0d_rsp_valid", i),
                32'(vecs[i].port == 0 ? p0_rsp_valid : p1_rsp_valid), 32'd1);
            chk($sformatf("vec%0d_rsp_err", i),
                32'(vecs[i].port == 0 ? p0_rsp_err : p1_rsp_err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_rsp_rdata", i),
                vecs[i].port == 0 ? p0_rsp_rdata : p1_rsp_rdata, vecs[i].exp_rdata);
            $display("vec %0d: port %0d we %0d unit %0d addr 0x%08h -> err %0d rdata 0x%08h",
                     i, vecs[i].port, vecs[i].we, vecs[i].unit, vecs[i].addr,
                     vecs[i].exp_err, vecs[i].exp_rdata);
            advance();
        end

        // Starvation: both ports valid every cycle; p1 must win on the 5th cycle, twice in a row.
        for (int round = 0; round < 2; round++) begin
            set_port(0, 1'b1, 1'b0, 3'd2, 32'h00, 32'd0);
            set_port(1, 1'b1, 1'b0, 3'd2, 32'(8 + 4 * round), 32'd0);
            p1_at = 0;
            for (int cyc = 1; cyc <= 12 && p1_at == 0; cyc++) begin
                tick();
                chk("both_ready", 32'(p0_ready && p1_ready), 32'd0);
                if (p1_ready) p1_at = cyc;
                advance();
            end
            chk($sformatf("starve_round%0d_p1_grant_cycle", round), 32'(p1_at), 32'd5);
            $display("starvation round %0d: p1 granted on cycle %0d", round, p1_at);
        end
        set_port(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        set_port(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        advance();

        // Alternating single-port loads every cycle; routing is checked by the model.
        for (int i = 0; i < 8; i++) begin
            set_port(i % 2, 1'b1, 1'b0, 3'd2, 32'(4 * i), 32'd0);
            set_port(1 - (i % 2), 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            tick();
            $display("alternate %0d: port %0d load word @0x%02h", i, i % 2, 4 * i);
            advance();
        end
        set_port(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        set_port(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        advance();

        // Reset the cycle after a grant: the pending response must vanish.
        set_port(0, 1'b1, 1'b0, 3'd2, 32'h04, 32'd0);
        tick();
        advance();
        rst = 1'b1;
        set_port(1, 1'b1, 1'b0, 3'd2, 32'h08, 32'd0);
        tick();
        chk("rst_p0_rsp_valid", 32'(p0_rsp_valid), 32'd0);
        chk("rst_p0_ready", 32'(p0_ready), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_unit", 32'(mem_unit), 32'd0);
        advance();
        rst = 1'b0;
        set_port(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        set_port(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        chk("post_rst_no_rsp", 32'(p0_rsp_valid || p1_rsp_valid), 32'd0);
        $display("reset during pending response: response dropped");
        advance();

        // Random traffic; requesters hold their request until the model says it was accepted.
        act0 = 1'b0;
        act1 = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!act0 && $urandom_range(0, 9) < 6) begin
                act0 = 1'b1;
                set_port(0, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                         ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 35)),
                         $urandom());
            end
            if (!act1 && $urandom_range(0, 9) < 6) begin
                act1 = 1'b1;
                set_port(1, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                         ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 35)),
                         $urandom());
            end
            p0_valid = act0;
            p1_valid = act1;
            rst = ($urandom_range(0, 99) == 0);
            tick();
            if (acc0 || acc1)
                $display("random %0d: grant port %0d", cyc, acc1 ? 1 : 0);
            if (acc0) act0 = 1'b0;
            if (acc1) act1 = 1'b0;
            advance();
        end
        rst = 1'b0;
        set_port(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        set_port(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        advance();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
